cond_decode_stage: RTL

//  Pipelined successor to the single-cycle decoder for the ARM-like CPU.

---
 rtl/cond_decode_stage.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/cond_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cond_decode_stage                                             |
// | Purpose  : D-stage decode, E-stage control register, NZCV flags and      |
// |            condition gating for the pipelined ARM-like core.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cond_decode_stage #(
    parameter int unsigned ALUCTRL_W   = 3,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000,
    parameter bit          LINK_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ValidD,
    input  logic [3:0]           CondD,
    input  logic [1:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic [3:0]           RdD,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic [3:0]           ALUFlags,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic                 ValidE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 MemtoRegE,
    output logic                 LinkE,
    output logic                 PCSrcE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 IllegalE,
    output logic [3:0]           Flags
);

    localparam logic [1:0] C_OP_DP  = 2'b00;
    localparam logic [1:0] C_OP_MEM = 2'b01;
    localparam logic [1:0] C_OP_BR  = 2'b10;

    localparam logic [2:0] C_ALU_ADD = 3'd0;
    localparam logic [2:0] C_ALU_SUB = 3'd1;
    localparam logic [2:0] C_ALU_AND = 3'd2;
    localparam logic [2:0] C_ALU_ORR = 3'd3;
    localparam logic [2:0] C_ALU_EOR = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic [2:0] alu;
        logic       alusrc;
        logic       memtoreg;
        logic       link;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       illegal;
    } ctrl_t;

    ctrl_t      w_ctrl_d;
    ctrl_t      r_ctrl_q;
    logic       w_arith;
    logic       w_cmp;
    logic [3:0] r_flags_q;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_pass;
    logic       w_cond_ex;

    // ------------------------------------------------------------------
    // D-stage decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl_d       = '0;
        w_ctrl_d.valid = ValidD;
        w_ctrl_d.cond  = CondD;
        w_ctrl_d.alu   = C_ALU_ADD;
        w_arith        = 1'b0;
        w_cmp          = 1'b0;
        RegSrcD        = 2'b00;
        ImmSrcD        = 2'b00;

        case (OpD)
            C_OP_DP: begin
                w_ctrl_d.alusrc = FunctD[5];
                w_ctrl_d.regw   = 1'b1;
                case (FunctD[4:1])
                    4'b0100: begin
                        w_ctrl_d.alu = C_ALU_ADD;
                        w_arith      = 1'b1;
                    end
                    4'b0010: begin
                        w_ctrl_d.alu = C_ALU_SUB;
                        w_arith      = 1'b1;
                    end
                    4'b0000: w_ctrl_d.alu = C_ALU_AND;
                    4'b1100: w_ctrl_d.alu = C_ALU_ORR;
                    4'b0001: w_ctrl_d.alu = C_ALU_EOR;
                    4'b1010: begin
                        w_ctrl_d.alu  = C_ALU_SUB;
                        w_ctrl_d.regw = 1'b0;
                        w_cmp         = 1'b1;
                    end
                    default: begin
                        w_ctrl_d.regw    = 1'b0;
                        w_ctrl_d.illegal = 1'b1;
                    end
                endcase
                // CMP always writes all four flags regardless of the S bit
                if (w_ctrl_d.illegal) begin
                    w_ctrl_d.flagw = 2'b00;
                end else if (w_cmp) begin
                    w_ctrl_d.flagw = 2'b11;
                end else if (FunctD[0]) begin
                    w_ctrl_d.flagw = w_arith ? 2'b11 : 2'b10;
                end
            end
            C_OP_MEM: begin
                w_ctrl_d.alusrc = 1'b1;
                ImmSrcD         = 2'b01;
                RegSrcD         = 2'b10;
                w_ctrl_d.alu    = FunctD[3] ? C_ALU_ADD : C_ALU_SUB;
                if (FunctD[0]) begin
                    w_ctrl_d.regw     = 1'b1;
                    w_ctrl_d.memtoreg = 1'b1;
                end else begin
                    w_ctrl_d.memw = 1'b1;
                end
            end
            C_OP_BR: begin
                w_ctrl_d.alusrc = 1'b1;
                ImmSrcD         = 2'b10;
                RegSrcD         = 2'b01;
                w_ctrl_d.alu    = C_ALU_ADD;
                w_ctrl_d.pcs    = 1'b1;
                if (FunctD[4] && LINK_EN) begin
                    w_ctrl_d.link = 1'b1;
                    w_ctrl_d.regw = 1'b1;
                end
            end
            default: begin
                w_ctrl_d.illegal = 1'b1;
            end
        endcase

        // A BL writes R14, so its Rd field never redirects the PC
        w_ctrl_d.pcs = w_ctrl_d.pcs |
                       (w_ctrl_d.regw & (RdD == 4'd15) & ~w_ctrl_d.link);
    end

    // ------------------------------------------------------------------
    // E-stage control register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_q <= '0;
        end else if (!StallE) begin
            if (FlushE || !ValidD) begin
                r_ctrl_q <= '0;
            end else begin
                r_ctrl_q <= w_ctrl_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation against the architectural flags
    // ------------------------------------------------------------------
    assign w_n = r_flags_q[3];
    assign w_z = r_flags_q[2];
    assign w_c = r_flags_q[1];
    assign w_v = r_flags_q[0];

    always_comb begin
        w_cond_pass = 1'b0;
        case (r_ctrl_q.cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign w_cond_ex = r_ctrl_q.valid & w_cond_pass;

    // Updating only on non-stalled edges gives exactly one write per instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags_q <= FLAGS_RESET;
        end else if (w_cond_ex && !StallE) begin
            if (r_ctrl_q.flagw[1]) begin
                r_flags_q[3:2] <= ALUFlags[3:2];
            end
            if (r_ctrl_q.flagw[0]) begin
                r_flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ValidE      = r_ctrl_q.valid;
    assign ALUControlE = ALUCTRL_W'(r_ctrl_q.alu);
    assign ALUSrcE     = r_ctrl_q.alusrc;
    assign MemtoRegE   = r_ctrl_q.memtoreg;
    assign LinkE       = r_ctrl_q.link;
    assign IllegalE    = r_ctrl_q.illegal;
    assign PCSrcE      = r_ctrl_q.pcs  & w_cond_ex;
    assign RegWriteE   = r_ctrl_q.regw & w_cond_ex;
    assign MemWriteE   = r_ctrl_q.memw & w_cond_ex;
    assign Flags       = r_flags_q;

endmodule
`default_nettype wire
